// File: rtl/bp_io_word_splitter.sv
// Splits 8-byte uncached BedRock I/O commands into two 4-byte sub-commands for the
// 32-bit manycore MMIO bridge and merges the two sub-responses back into one response.

module bp_io_word_splitter_chk
    #(parameter int size_width_p = 3)
    (input  logic                    clk_i
    ,input  logic                    reset_n_i
    ,input  logic                    cmd_fire_i
    ,input  logic [size_width_p-1:0] cmd_size_i
    ,input  logic [2:0]              cmd_addr_lo_i
    ,input  logic                    resp_v_i
    ,input  logic                    resp_ready_i
    ,input  logic                    resp_v_o_i
    ,input  logic                    resp_yumi_i
    );

    localparam logic [size_width_p-1:0] size_8_lp = 3'd3;

    a_aligned_split: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(cmd_fire_i && (cmd_size_i == size_8_lp) && (cmd_addr_lo_i != 3'b000)))
        else $error("size-8 parent accepted with misaligned address");

    a_no_spurious_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(resp_v_i && !resp_ready_i))
        else $error("sub-response presented while no sub-command outstanding");

    a_yumi_with_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(resp_yumi_i && !resp_v_o_i))
        else $error("merged response yumi without valid");

endmodule

module bp_io_word_splitter
    #(parameter int paddr_width_p    = 40
     ,parameter int mc_data_width_p  = 32
     ,parameter int word_width_gp    = 64
     ,parameter int msg_type_width_p = 4
     ,parameter int payload_width_p  = 8
     ,localparam int size_width_lp        = 3
     ,localparam int hdr_width_lp         = msg_type_width_p + paddr_width_p + size_width_lp + payload_width_p
     ,localparam int cce_mem_msg_width_lp = hdr_width_lp + word_width_gp
     )
    (input  logic                            clk_i
    ,input  logic                            reset_n_i

    ,input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i
    ,input  logic                            io_cmd_v_i
    ,output logic                            io_cmd_ready_o

    ,output logic [cce_mem_msg_width_lp-1:0] io_cmd_o
    ,output logic                            io_cmd_v_o
    ,input  logic                            io_cmd_ready_i

    ,input  logic [cce_mem_msg_width_lp-1:0] io_resp_i
    ,input  logic                            io_resp_v_i
    ,output logic                            io_resp_ready_o

    ,output logic [cce_mem_msg_width_lp-1:0] io_resp_o
    ,output logic                            io_resp_v_o
    ,input  logic                            io_resp_yumi_i
    );

    // Message layout: {data, payload, size, addr, msg_type}, msg_type in the LSBs.
    localparam int addr_lsb_lp = msg_type_width_p;
    localparam int size_lsb_lp = addr_lsb_lp + paddr_width_p;
    localparam int pad_width_lp = word_width_gp - mc_data_width_p;
    localparam logic [size_width_lp-1:0] size_4_lp = 3'd2;
    localparam logic [size_width_lp-1:0] size_8_lp = 3'd3;

    typedef enum logic [2:0] {
        e_ready   = 3'd0,
        e_send_lo = 3'd1,
        e_send_hi = 3'd2,
        e_wait_lo = 3'd3,
        e_wait_hi = 3'd4,
        e_resp    = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic [hdr_width_lp-1:0]    hdr_q, hdr_d;
    logic [word_width_gp-1:0]   data_q, data_d;
    logic                       split_q, split_d;
    logic [mc_data_width_p-1:0] lo_q, lo_d;
    logic [mc_data_width_p-1:0] hi_q, hi_d;

    logic [hdr_width_lp-1:0]    sub_hdr_lo_s, sub_hdr_hi_s;
    logic [word_width_gp-1:0]   merged_data_s;
    logic                       unused_resp_s;

    // Only the low word of each sub-response carries data.
    assign unused_resp_s = ^{io_resp_i[hdr_width_lp-1:0],
                             io_resp_i[cce_mem_msg_width_lp-1:hdr_width_lp+mc_data_width_p]};

    // State and transaction registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_ready;
            hdr_q   <= '0;
            data_q  <= '0;
            split_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            split_q <= split_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Next-state logic; ready outputs come from state decode, so v_i never reaches ready_o.
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        split_d = split_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            e_ready: begin
                if (io_cmd_v_i) begin
                    hdr_d   = io_cmd_i[hdr_width_lp-1:0];
                    data_d  = io_cmd_i[cce_mem_msg_width_lp-1 -: word_width_gp];
                    split_d = (io_cmd_i[size_lsb_lp +: size_width_lp] == size_8_lp);
                    state_d = e_send_lo;
                end else begin
                    state_d = e_ready;
                end
            end
            e_send_lo: begin
                if (io_cmd_ready_i) begin
                    state_d = split_q ? e_send_hi : e_wait_lo;
                end else begin
                    state_d = e_send_lo;
                end
            end
            e_send_hi: begin
                if (io_cmd_ready_i) begin
                    state_d = e_wait_lo;
                end else begin
                    state_d = e_send_hi;
                end
            end
            e_wait_lo: begin
                if (io_resp_v_i) begin
                    lo_d    = io_resp_i[hdr_width_lp +: mc_data_width_p];
                    state_d = split_q ? e_wait_hi : e_resp;
                end else begin
                    state_d = e_wait_lo;
                end
            end
            e_wait_hi: begin
                if (io_resp_v_i) begin
                    hi_d    = io_resp_i[hdr_width_lp +: mc_data_width_p];
                    state_d = e_resp;
                end else begin
                    state_d = e_wait_hi;
                end
            end
            e_resp: begin
                if (io_resp_yumi_i) begin
                    state_d = e_ready;
                end else begin
                    state_d = e_resp;
                end
            end
            default: begin
                state_d = e_ready;
            end
        endcase
    end

    // Sub-command headers: split parents use the aligned 8-byte base, lo word first.
    always_comb begin
        sub_hdr_lo_s = hdr_q;
        sub_hdr_hi_s = hdr_q;
        if (split_q) begin
            sub_hdr_lo_s[addr_lsb_lp +: paddr_width_p] = {hdr_q[addr_lsb_lp+3 +: paddr_width_p-3], 3'b000};
            sub_hdr_lo_s[size_lsb_lp +: size_width_lp] = size_4_lp;
            sub_hdr_hi_s[addr_lsb_lp +: paddr_width_p] = {hdr_q[addr_lsb_lp+3 +: paddr_width_p-3], 3'b100};
            sub_hdr_hi_s[size_lsb_lp +: size_width_lp] = size_4_lp;
        end else begin
            sub_hdr_lo_s = hdr_q;
            sub_hdr_hi_s = hdr_q;
        end
    end

    assign merged_data_s = split_q ? {hi_q, lo_q} : {{pad_width_lp{1'b0}}, lo_q};

    // Output decode; data buses are held at zero whenever their valid is low.
    always_comb begin
        io_cmd_ready_o  = 1'b0;
        io_cmd_o        = '0;
        io_cmd_v_o      = 1'b0;
        io_resp_ready_o = 1'b0;
        io_resp_o       = '0;
        io_resp_v_o     = 1'b0;
        case (state_q)
            e_ready: begin
                io_cmd_ready_o = 1'b1;
            end
            e_send_lo: begin
                io_cmd_v_o = 1'b1;
                io_cmd_o   = {{pad_width_lp{1'b0}}, data_q[mc_data_width_p-1:0], sub_hdr_lo_s};
            end
            e_send_hi: begin
                io_cmd_v_o = 1'b1;
                io_cmd_o   = {{pad_width_lp{1'b0}}, data_q[word_width_gp-1 -: mc_data_width_p], sub_hdr_hi_s};
            end
            e_wait_lo, e_wait_hi: begin
                io_resp_ready_o = 1'b1;
            end
            e_resp: begin
                io_resp_v_o = 1'b1;
                io_resp_o   = {merged_data_s, hdr_q};
            end
            default: begin
                io_cmd_ready_o = 1'b0;
            end
        endcase
    end

    bp_io_word_splitter_chk #(.size_width_p(size_width_lp)) chk (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .cmd_fire_i    (io_cmd_v_i & io_cmd_ready_o),
        .cmd_size_i    (io_cmd_i[size_lsb_lp +: size_width_lp]),
        .cmd_addr_lo_i (io_cmd_i[addr_lsb_lp +: 3]),
        .resp_v_i      (io_resp_v_i),
        .resp_ready_i  (io_resp_ready_o),
        .resp_v_o_i    (io_resp_v_o),
        .resp_yumi_i   (io_resp_yumi_i)
    );

endmodule

// File: tb/tb_bp_io_word_splitter.sv
// Directed bench for bp_io_word_splitter: a transaction-level model predicts every
// sub-command and merged response; literal checks pin addresses, data and latency.

module tb_bp_io_word_splitter;

    localparam int MSG_W = 119;
    localparam logic [3:0] UC_RD = 4'd0;
    localparam logic [3:0] UC_WR = 4'd1;
    localparam logic [2:0] SZ2 = 3'd1;
    localparam logic [2:0] SZ4 = 3'd2;
    localparam logic [2:0] SZ8 = 3'd3;
    localparam logic [7:0] PAYLOAD = 8'hC3;

    logic             clk;
    logic             rst_n;
    logic [MSG_W-1:0] io_cmd_i, io_cmd_o, io_resp_i, io_resp_o;
    logic             io_cmd_v_i, io_cmd_ready_o, io_cmd_v_o, io_cmd_ready_i;
    logic             io_resp_v_i, io_resp_ready_o, io_resp_v_o, io_resp_yumi_i;

    int n_pass = 0;
    int n_total = 0;
    logic [MSG_W-1:0] exp_cmd_q[$];
    logic [MSG_W-1:0] exp_resp_q[$];

    bp_io_word_splitter dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o),
        .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [MSG_W-1:0] mk_msg(logic [3:0] typ, logic [39:0] addr,
                                                logic [2:0] size, logic [63:0] data);
        return {data, PAYLOAD, size, addr, typ};
    endfunction

    function automatic logic [39:0] f_addr(logic [MSG_W-1:0] m); return m[43:4];   endfunction
    function automatic logic [2:0]  f_size(logic [MSG_W-1:0] m); return m[46:44];  endfunction
    function automatic logic [63:0] f_data(logic [MSG_W-1:0] m); return m[118:55]; endfunction

    // Model: predict the sub-commands and the merged response of one parent, then offer it.
    task automatic offer(input logic [3:0] typ, input logic [39:0] addr, input logic [2:0] size,
                         input logic [63:0] data, input logic [31:0] rlo, input logic [31:0] rhi);
        logic [39:0] base;
        base = addr & ~40'h7;
        if (size == SZ8) begin
            exp_cmd_q.push_back(mk_msg(typ, base, SZ4, {32'h0, data[31:0]}));
            exp_cmd_q.push_back(mk_msg(typ, base + 40'h4, SZ4, {32'h0, data[63:32]}));
            exp_resp_q.push_back(mk_msg(typ, addr, size, {rhi, rlo}));
        end else begin
            exp_cmd_q.push_back(mk_msg(typ, addr, size, {32'h0, data[31:0]}));
            exp_resp_q.push_back(mk_msg(typ, addr, size, {32'h0, rlo}));
        end
        io_cmd_i   = mk_msg(typ, addr, size, data);
        io_cmd_v_i = 1'b1;
    endtask

    task automatic accept();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (io_cmd_ready_o) done = 1'b1;
            @(posedge clk); #1;
        end
        io_cmd_v_i = 1'b0;
        chk("accept_timeout", done, 1);
    endtask

    task automatic give_resp(input logic [31:0] word);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (io_resp_ready_o) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("resp_ready_timeout", ok, 1);
        if (ok) begin
            io_resp_i   = {32'hFFFF_0000, word, 55'h0_1234};
            io_resp_v_i = 1'b1;
            @(posedge clk); #1;
            io_resp_v_i = 1'b0;
        end
    endtask

    task automatic take_resp();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (io_resp_v_o) begin
                io_resp_yumi_i = 1'b1;
                done = 1'b1;
            end
            @(posedge clk); #1;
            io_resp_yumi_i = 1'b0;
        end
        chk("resp_valid_timeout", done, 1);
    endtask

    // Compare process: every valid output cycle is checked against the model's head entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (io_cmd_v_o) begin
                if (exp_cmd_q.size() == 0) chk("cmd_unexpected", io_cmd_v_o, 0);
                else begin
                    chk("cmd_model", io_cmd_o, exp_cmd_q[0]);
                    if (io_cmd_ready_i) exp_cmd_q.delete(0);
                end
            end
            if (io_resp_v_o) begin
                if (exp_resp_q.size() == 0) chk("resp_unexpected", io_resp_v_o, 0);
                else begin
                    chk("resp_model", io_resp_o, exp_resp_q[0]);
                    if (io_resp_yumi_i) exp_resp_q.delete(0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        io_cmd_i = '0; io_cmd_v_i = 1'b0; io_cmd_ready_i = 1'b1;
        io_resp_i = '0; io_resp_v_i = 1'b0; io_resp_yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_v", io_cmd_v_o, 0);
        chk("rst_resp_v", io_resp_v_o, 0);
        chk("rst_resp_ready", io_resp_ready_o, 0);
        chk("rst_cmd_ready", io_cmd_ready_o, 1);
        chk("rst_cmd_data", io_cmd_o, 0);
        chk("rst_resp_data", io_resp_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 8B read, no backpressure: lo at cycle 1, hi at cycle 2
        offer(UC_RD, 40'h00_0010_0008, SZ8, 64'h0, 32'hDEADBEEF, 32'h01234567);
        accept();
        chk("t1_lo_v", io_cmd_v_o, 1);
        chk("t1_lo_addr", f_addr(io_cmd_o), 40'h00_0010_0008);
        chk("t1_lo_size", f_size(io_cmd_o), SZ4);
        @(posedge clk); #1;
        chk("t1_hi_v", io_cmd_v_o, 1);
        chk("t1_hi_addr", f_addr(io_cmd_o), 40'h00_0010_000C);
        chk("t1_hi_size", f_size(io_cmd_o), SZ4);
        @(posedge clk); #1;
        chk("t1_cmd_idle", io_cmd_v_o, 0);
        give_resp(32'hDEADBEEF);
        give_resp(32'h01234567);
        chk("t1_resp_latency", io_resp_v_o, 1);
        chk("t1_resp_data", f_data(io_resp_o), 64'h01234567_DEADBEEF);
        chk("t1_resp_addr", f_addr(io_resp_o), 40'h00_0010_0008);
        chk("t1_resp_size", f_size(io_resp_o), SZ8);
        take_resp();
        chk("t1_drain", exp_cmd_q.size() + exp_resp_q.size(), 0);

        // 8B write: data split lo/hi, parent port closed until the response is consumed
        offer(UC_WR, 40'h00_0010_0010, SZ8, 64'hAAAA5555_12345678, 32'h1, 32'h2);
        accept();
        chk("t2_lo_data", f_data(io_cmd_o), 64'h12345678);
        chk("t2_ready_lo", io_cmd_ready_o, 0);
        @(posedge clk); #1;
        chk("t2_hi_data", f_data(io_cmd_o), 64'hAAAA5555);
        chk("t2_ready_hi", io_cmd_ready_o, 0);
        give_resp(32'h1);
        chk("t2_ready_wait", io_cmd_ready_o, 0);
        give_resp(32'h2);
        chk("t2_ready_resp", io_cmd_ready_o, 0);
        take_resp();
        chk("t2_ready_after", io_cmd_ready_o, 1);

        // 2B read: exactly one sub-command, response zero-extended
        offer(UC_RD, 40'h00_0010_0006, SZ2, 64'h11112222_33334444, 32'h0000BEEF, 32'h0);
        accept();
        chk("t3_addr", f_addr(io_cmd_o), 40'h00_0010_0006);
        chk("t3_size", f_size(io_cmd_o), SZ2);
        @(posedge clk); #1;
        chk("t3_single_subcmd", io_cmd_v_o, 0);
        chk("t3_wait_ready", io_resp_ready_o, 1);
        give_resp(32'h0000BEEF);
        chk("t3_resp_data", f_data(io_resp_o), 64'h00000000_0000BEEF);
        take_resp();

        // Backpressure on both sides
        io_cmd_ready_i = 1'b0;
        offer(UC_RD, 40'h00_0010_0020, SZ8, 64'h0, 32'hCAFEF00D, 32'h8BADF00D);
        accept();
        for (int i = 0; i < 5; i++) begin
            chk("t4_cmd_hold", io_cmd_v_o, 1);
            @(posedge clk); #1;
        end
        io_cmd_ready_i = 1'b1;
        give_resp(32'hCAFEF00D);
        give_resp(32'h8BADF00D);
        for (int i = 0; i < 4; i++) begin
            chk("t4_resp_hold", io_resp_v_o, 1);
            chk("t4_cmd_ready_low", io_cmd_ready_o, 0);
            @(posedge clk); #1;
        end
        take_resp();

        // Second parent offered while the first waits for its hi word
        offer(UC_RD, 40'h00_0010_0030, SZ8, 64'h0, 32'h11111111, 32'h22222222);
        accept();
        give_resp(32'h11111111);
        offer(UC_WR, 40'h00_0010_0040, SZ4, 64'h0000_0000_5A5A_A5A5, 32'h77777777, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("t5_stalled", io_cmd_ready_o, 0);
            @(posedge clk); #1;
        end
        give_resp(32'h22222222);
        chk("t5_stalled_resp", io_cmd_ready_o, 0);
        take_resp();
        chk("t5_ready_after_yumi", io_cmd_ready_o, 1);
        accept();
        chk("t5_b_sent", io_cmd_v_o, 1);
        chk("t5_b_addr", f_addr(io_cmd_o), 40'h00_0010_0040);
        chk("t5_b_size", f_size(io_cmd_o), SZ4);
        give_resp(32'h77777777);
        take_resp();

        // Reset while waiting for the lo sub-response
        offer(UC_RD, 40'h00_0010_0050, SZ8, 64'h0, 32'h0, 32'h0);
        accept();
        repeat (2) @(posedge clk);
        #1;
        chk("t6_in_wait", io_resp_ready_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cmd_v", io_cmd_v_o, 0);
        chk("t6_rst_resp_v", io_resp_v_o, 0);
        chk("t6_rst_resp_ready", io_resp_ready_o, 0);
        chk("t6_rst_cmd_ready", io_cmd_ready_o, 1);
        exp_cmd_q.delete();
        exp_resp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_ready_after_rst", io_cmd_ready_o, 1);
        offer(UC_RD, 40'h00_0010_0058, SZ8, 64'h0, 32'hA5A50001, 32'h5A5A0002);
        accept();
        give_resp(32'hA5A50001);
        give_resp(32'h5A5A0002);
        chk("t6_resp_data", f_data(io_resp_o), 64'h5A5A0002_A5A50001);
        take_resp();
        chk("final_drain", exp_cmd_q.size() + exp_resp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
